systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Result-collection end of the systolic control handshake. The array controller holds `ctrl` high during compute and drops it when compute finishes.
- This block watches that signal. On the high-to-low transition it snapshots the array accumulator outputs.
- It then streams the snapshot out one row per transfer over a valid/ready interface, and pulses `done` when the last row has been accepted.

Parameters:
- ROW, 4: number of array rows, i.e. the number of output words per drain; must be >= 2.
- COL, 4: number of array columns, i.e. elements per output word.
- DW, 16: accumulator element width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ctrl_in  input  1  compute-active flag from the array controller.
- acc_in  input  ROW*COL*DW  accumulator outputs; row r occupies bits [r*COL*DW +: COL*DW]; element c within a row occupies [c*DW +: DW].
- out_ready  input  1  downstream can accept a word.
- out_valid  output  1  out_data/out_row hold a valid word.
- out_data  output  COL*DW  current row word.
- out_row  output  max(1,$clog2(ROW))  index of the row on out_data.
- busy  output  1  high in ARMED, DRAIN and DONE.
- done  output  1  single-cycle pulse after the final row is accepted.
- overrun  output  1  sticky: controller restarted compute while a drain was in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, row_idx=0, snapshot=0.
  - out_valid=0, out_data=0, out_row=0, busy=0, done=0, overrun=0.
  - Reset asserted mid-drain aborts the drain immediately; no done pulse is produced.
- States:
  - IDLE -> ARMED when ctrl_in=1 (level).
  - ARMED -> DRAIN when ctrl_in=0 (compute finished). On that same edge: capture acc_in into snapshot, set row_idx=0.
  - DRAIN: out_valid=1 and out_row=row_idx. out_data=snapshot row row_idx, driven from registers only with no combinational path from acc_in.
    - Transfer = out_valid && out_ready at a rising edge.
    - On a transfer with row_idx<ROW-1: row_idx increments; out_valid stays 1.
    - On a transfer with row_idx=ROW-1: -> DONE.
  - DONE: out_valid=0, done=1 for exactly one cycle, -> IDLE.
- Latency:
  - First word is valid the cycle after the edge at which ctrl_in was sampled 0 in ARMED.
  - With out_ready held 1, ROW words are delivered in ROW consecutive cycles, and done follows in the next cycle.
- Handshake rules:
  - out_valid never deasserts without a transfer.
  - out_data and out_row are stable while out_valid=1 and out_ready=0.
  - out_ready is ignored outside DRAIN.
- Snapshot: acc_in changes after capture have no effect on the words being output.
- ctrl_in pulse of exactly one cycle: IDLE->ARMED, then falls -> DRAIN. This is a legal short compute.
- Overrun: ctrl_in sampled 1 while in DRAIN or DONE sets overrun=1, which holds until reset.
  - The current drain completes unaffected.
  - If ctrl_in is still 1 when the block returns to IDLE, it arms normally on the next edge.
- Back-to-back operation: done and a new IDLE->ARMED transition never share a cycle. The minimum gap is one IDLE cycle.
- out_row width: row_idx wraps only by the explicit return to 0 on capture; it never counts past ROW-1.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_PARITY_EN
- Defined: adds output out_parity (1 bit), the even parity (XOR reduction) of out_data. It is registered alongside out_data and follows the same valid and stability rules. It is 0 in reset and whenever out_valid=0.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Basic drain: ROW=4, COL=4, DW=16, acc_in element (r,c)=16'h0r0c. ctrl_in high 4 cycles then low, out_ready=1 -> 4 consecutive words with out_row 0..3; word 1 = {16'h0103,16'h0102,16'h0101,16'h0100}; done pulses 1 cycle after word 3; busy returns to 0.
- Backpressure: same setup, out_ready=0 for 3 cycles on row 2 -> out_valid stays 1, out_data/out_row frozen at row 2 throughout; drain then completes with no word lost or duplicated.
- Snapshot isolation: change acc_in to all 16'hFFFF one cycle after capture -> all 4 words still carry the pre-capture values.
- Overrun: raise ctrl_in during row 1 of a drain and hold it -> overrun=1 and sticky; the current 4 rows complete; the block re-arms and a second drain follows after ctrl_in falls.
- Reset mid-drain: assert rst during row 2 -> out_valid=0, done never pulses, overrun=0, state IDLE; a subsequent ctrl_in pulse drains normally from row 0.
- Parity (macro defined): row word 32'h0000_0001 packed in COL=2, DW=16 -> out_parity=1; row word all zeros -> out_parity=0.

Source files
------------

// File: rtl/systolic_drain.sv
// Collects systolic array results: snapshots acc_in when ctrl_in falls, then streams one row per transfer.
// Latency: first word valid the cycle after ctrl_in is seen low while armed; ROW words back-to-back, then done.
// Backpressure: out_valid holds with stable out_data/out_row until out_ready; SYSTOLIC_DRAIN_PARITY_EN adds out_parity.
module systolic_drain #(
    parameter int ROW = 4,
    parameter int COL = 4,
    parameter int DW  = 16,
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_in,
    input  logic [ROW*COL*DW-1:0]  acc_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [COL*DW-1:0]      out_data,
    output logic [RW-1:0]          out_row,
`ifdef SYSTOLIC_DRAIN_PARITY_EN
    output logic                   out_parity,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int WW = COL * DW;
    localparam logic [RW-1:0] LAST = RW'(ROW - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ROW*WW-1:0]   snapshot;
    logic [RW-1:0]       row_idx;
    logic [RW-1:0]       row_inc;
    logic [WW-1:0]       data_q;
    logic                overrun_q;
    logic                capture;
    logic                xfer;

    assign row_inc = row_idx + RW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_in) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!ctrl_in) begin
                    state_next = DRAIN;
                    capture    = 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (row_idx == LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The output word is its own register, preloaded with the next row on
    // each transfer, so out_data never depends combinationally on acc_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snapshot  <= '0;
            row_idx   <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (capture) begin
                snapshot <= acc_in;
                row_idx  <= '0;
                data_q   <= acc_in[WW-1:0];
            end else if (xfer && (row_idx != LAST)) begin
                row_idx <= row_inc;
                data_q  <= snapshot[int'(row_inc)*WW +: WW];
            end
            if (ctrl_in && ((state == DRAIN) || (state == DONE))) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef SYSTOLIC_DRAIN_PARITY_EN
    logic parity_q;

    // Cleared on the final transfer so it reads 0 whenever out_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (capture) begin
            parity_q <= ^acc_in[WW-1:0];
        end else if (xfer) begin
            if (row_idx != LAST) begin
                parity_q <= ^snapshot[int'(row_inc)*WW +: WW];
            end else begin
                parity_q <= 1'b0;
            end
        end
    end

    assign out_parity = parity_q;
`endif

    assign out_valid = (state == DRAIN);
    assign out_data  = data_q;
    assign out_row   = row_idx;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: per-cycle vector table plus hand-written corner sequences.
module tb_systolic_drain;

    logic         clk;
    logic         rst;
    logic         ctrl_in;
    logic [255:0] acc_in;
    logic         out_ready;
    logic         out_valid;
    logic [63:0]  out_data;
    logic [1:0]   out_row;
    logic         busy;
    logic         done;
    logic         overrun;
`ifdef SYSTOLIC_DRAIN_PARITY_EN
    logic         out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    systolic_drain #(.ROW(4), .COL(4), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_in   (ctrl_in),
        .acc_in    (acc_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
`ifdef SYSTOLIC_DRAIN_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ctrl;
        logic       rdy;
        logic       ev;
        logic [1:0] er;
        logic       eb;
        logic       ed;
        logic       eo;
    } vec_t;

    vec_t vecs[20];

    // Element (r,c) = 16'h0r0c.
    function automatic logic [63:0] row_word(input int r);
        logic [63:0] w;
        for (int c = 0; c < 4; c++) begin
            w[c*16 +: 16] = {8'(r), 8'(c)};
        end
        return w;
    endfunction

    function automatic logic [255:0] pattern();
        logic [255:0] a;
        for (int r = 0; r < 4; r++) begin
            a[r*64 +: 64] = row_word(r);
        end
        return a;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects DRAIN at row 0 now; drives out_ready=1 and checks all rows, done, return to idle.
    task automatic expect_drain(input string name, input logic [255:0] acc);
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chkb($sformatf("%s r%0d valid", name, r), out_valid, 1'b1);
            chk($sformatf("%s r%0d row", name, r), 64'(out_row), 64'(r));
            chk($sformatf("%s r%0d data", name, r), out_data, acc[r*64 +: 64]);
            tick();
        end
        chkb({name, " done"}, done, 1'b1);
        chkb({name, " valid_at_done"}, out_valid, 1'b0);
        tick();
        chkb({name, " done_once"}, done, 1'b0);
        chkb({name, " idle"}, busy, 1'b0);
    endtask

    initial begin
        vecs[0]  = 8'b1_1_0_00_1_0_0;
        vecs[1]  = 8'b1_1_0_00_1_0_0;
        vecs[2]  = 8'b1_1_0_00_1_0_0;
        vecs[3]  = 8'b1_1_0_00_1_0_0;
        vecs[4]  = 8'b0_1_1_00_1_0_0;
        vecs[5]  = 8'b0_1_1_01_1_0_0;
        vecs[6]  = 8'b0_1_1_10_1_0_0;
        vecs[7]  = 8'b0_1_1_11_1_0_0;
        vecs[8]  = 8'b0_1_0_00_1_1_0;
        vecs[9]  = 8'b0_1_0_00_0_0_0;
        vecs[10] = 8'b1_1_0_00_1_0_0;
        vecs[11] = 8'b0_1_1_00_1_0_0;
        vecs[12] = 8'b0_1_1_01_1_0_0;
        vecs[13] = 8'b0_1_1_10_1_0_0;
        vecs[14] = 8'b0_0_1_10_1_0_0;
        vecs[15] = 8'b0_0_1_10_1_0_0;
        vecs[16] = 8'b0_0_1_10_1_0_0;
        vecs[17] = 8'b0_1_1_11_1_0_0;
        vecs[18] = 8'b0_1_0_00_1_1_0;
        vecs[19] = 8'b0_1_0_00_0_0_0;

        rst       = 1'b0;
        ctrl_in   = 1'b0;
        out_ready = 1'b0;
        acc_in    = pattern();
        #12;
        chkb("rst valid", out_valid, 1'b0);
        chk("rst data", out_data, 64'h0);
        chk("rst row", 64'(out_row), 64'h0);
        chkb("rst busy", busy, 1'b0);
        chkb("rst done", done, 1'b0);
        chkb("rst overrun", overrun, 1'b0);
`ifdef SYSTOLIC_DRAIN_PARITY_EN
        chkb("rst parity", out_parity, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Basic drain (vectors 0-9) then backpressure on row 2 (vectors 10-19).
        for (int i = 0; i < 20; i++) begin
            ctrl_in   = vecs[i].ctrl;
            out_ready = vecs[i].rdy;
            tick();
            chkb($sformatf("v%0d valid", i), out_valid, vecs[i].ev);
            chkb($sformatf("v%0d busy", i), busy, vecs[i].eb);
            chkb($sformatf("v%0d done", i), done, vecs[i].ed);
            chkb($sformatf("v%0d overrun", i), overrun, vecs[i].eo);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d row", i), 64'(out_row), 64'(vecs[i].er));
                chk($sformatf("v%0d data", i), out_data, row_word(int'(vecs[i].er)));
            end
            if (i == 5) begin
                chk("word1 literal", out_data, 64'h0103_0102_0101_0100);
            end
        end

        // Snapshot isolation: acc_in goes all-ones right after capture.
        out_ready = 1'b0;
        ctrl_in   = 1'b1;
        tick();
        ctrl_in = 1'b0;
        tick();
        acc_in = {256{1'b1}};
        tick();
        expect_drain("snap", pattern());
        acc_in = pattern();

        // Overrun: ctrl_in rises during row 1 and stays high.
        ctrl_in = 1'b1;
        tick();
        ctrl_in   = 1'b0;
        out_ready = 1'b1;
        tick();
        chkb("ovr pre", overrun, 1'b0);
        tick();
        chk("ovr row1", 64'(out_row), 64'd1);
        ctrl_in = 1'b1;
        tick();
        chkb("ovr set", overrun, 1'b1);
        chk("ovr row2", 64'(out_row), 64'd2);
        chk("ovr data2", out_data, row_word(2));
        tick();
        chk("ovr row3", 64'(out_row), 64'd3);
        tick();
        chkb("ovr done", done, 1'b1);
        tick();
        chkb("ovr idle", busy, 1'b0);
        tick();
        chkb("ovr rearm", busy, 1'b1);
        chkb("ovr rearm valid", out_valid, 1'b0);
        ctrl_in = 1'b0;
        tick();
        expect_drain("ovr2", pattern());
        chkb("ovr sticky", overrun, 1'b1);

        // Reset during row 2 aborts the drain and clears overrun.
        ctrl_in = 1'b1;
        tick();
        ctrl_in = 1'b0;
        tick();
        tick();
        tick();
        chk("rmid row2", 64'(out_row), 64'd2);
        rst = 1'b0;
        #1;
        chkb("rmid valid", out_valid, 1'b0);
        chkb("rmid busy", busy, 1'b0);
        chkb("rmid overrun", overrun, 1'b0);
        chk("rmid row", 64'(out_row), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chkb($sformatf("rmid nodone%0d", k), done, 1'b0);
            chkb($sformatf("rmid idle%0d", k), busy, 1'b0);
        end
        ctrl_in = 1'b1;
        tick();
        ctrl_in = 1'b0;
        tick();
        expect_drain("rpost", pattern());

`ifdef SYSTOLIC_DRAIN_PARITY_EN
        acc_in = {64'h8000_0000_0000_0000, 64'h3, 64'h0, 64'h1};
        ctrl_in = 1'b1;
        tick();
        ctrl_in   = 1'b0;
        out_ready = 1'b0;
        tick();
        chkb("par r0", out_parity, 1'b1);
        out_ready = 1'b1;
        tick();
        chkb("par r1", out_parity, 1'b0);
        tick();
        chkb("par r2", out_parity, 1'b0);
        tick();
        chkb("par r3", out_parity, 1'b1);
        tick();
        chkb("par done", out_parity, 1'b0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
